eco_pattern_checker: RTL
========================

// Module: eco_pattern_checker
// PURPOSE
//   Sequential driver/checker on the far side of a small combinational ECO test netlist
//   (inputs a[3:0], b[3:0]; output y[3:0]).
//   - Sweeps all 2^(2*IN_W) {b,a} input patterns into the netlist under test.
//   - Samples its output y_in against a golden netlist output y_ref.
//   - Compacts y_in into a MISR signature.
//   - Reports first failing pattern and total mismatch count.
//   Used to confirm that a patched netlist is equivalent to its original.
// PARAMETERS
//   IN_W       4        width of each stimulus bus a_out / b_out
//   OUT_W      4        width of y_in / y_ref / signature
//   SEED       4'b0001  MISR value loaded on start and on reset
//   MISR_POLY  4'b0011  feedback taps (x^4+x+1) XORed in when signature MSB is 1
//   SETTLE     1        wait cycles between applying a pattern and sampling (0 allowed)
// PORTS
//   clk        in   1          single clock; all state on rising edge
//   rst        in   1          synchronous, active-high reset
//   start      in   1          begin sweep; sampled only in IDLE
//   a_out      out  IN_W       stimulus a to both netlists (registered)
//   b_out      out  IN_W       stimulus b to both netlists (registered)
//   y_in       in   OUT_W      output of netlist under test
//   y_ref      in   OUT_W      output of golden netlist
//   busy       out  1          high from cycle after accepted start until DONE
//   done       out  1          one-cycle pulse at end of sweep
//   signature  out  OUT_W      MISR result; held after done until next start
//   mismatch   out  1          sticky: any y_in != y_ref during sweep
//   fail_vec   out  2*IN_W     {b,a} of first mismatching pattern; 0 if none
//   fail_cnt   out  2*IN_W+1   number of mismatching patterns (max 2^(2*IN_W))
// BEHAVIOUR
//   Reset: state IDLE; a_out=b_out=0; busy=done=mismatch=0; fail_vec=fail_cnt=0;
//     signature=SEED; pattern counter cnt=0. Reset mid-sweep aborts; no done pulse.
//   FSM: IDLE -> APPLY -> SETTLE -> SAMPLE -> (APPLY | DONE) -> IDLE.
//   - IDLE: on start, clear cnt/mismatch/fail_vec/fail_cnt, signature=SEED, go APPLY.
//     start in any other state is ignored.
//   - APPLY: {b_out,a_out} <= cnt[2*IN_W-1:0]; go SETTLE (straight to SAMPLE if SETTLE=0).
//   - SETTLE: stay exactly SETTLE cycles.
//   - SAMPLE: compare and compact, then cnt++. Go DONE if cnt was 2^(2*IN_W)-1, else APPLY.
//   - DONE: done=1, busy=0 next; return to IDLE; a_out/b_out keep last pattern.
//   MISR per SAMPLE: sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : 0) ^ y_in.
//   Compare per SAMPLE when y_in != y_ref:
//     - mismatch <= 1; fail_cnt <= fail_cnt+1.
//     - fail_vec <= {b_out,a_out} only if mismatch was 0 (first failure).
//   Timing: each pattern costs 2+SETTLE cycles; done asserts
//     2^(2*IN_W)*(2+SETTLE)+1 cycles after start accepted (769 for defaults).
//   cnt is 2*IN_W+1 bits wide; it never wraps within a sweep.
//   fail_cnt cannot overflow.
//   X on y_in/y_ref outside SAMPLE has no effect.
// TESTING
//   1 rst high 2 cycles -> all outputs 0, signature=4'b0001, busy=0.
//   2 y_in=y_ref=0 constant, start -> done exactly once at cycle 769;
//     signature=4'b0010 (256 shifts, period 15); mismatch=0; fail_cnt=0.
//   3 y_in=y_ref=bench model of golden netlist -> mismatch=0;
//     signature equals bench MISR model.
//   4 y_in differs from y_ref only at a=4'h5,b=4'h3 -> mismatch=1, fail_cnt=1, fail_vec=8'h35.
//   5 y_in=~y_ref always -> fail_cnt=9'd256, fail_vec=8'h00, mismatch=1.
//   6 start pulsed while busy -> ignored, sweep timing unchanged.
//     rst at pattern 100 -> next cycle IDLE, all reset values, no done.

Source files
------------

// File: rtl/eco_pattern_checker_if.sv
// eco_pattern_checker_if: stimulus, response and status bundle between the checker and its environment
interface eco_pattern_checker_if #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 4
);
   logic                start;
   logic [IN_W-1:0]     a_out;
   logic [IN_W-1:0]     b_out;
   logic [OUT_W-1:0]    y_in;
   logic [OUT_W-1:0]    y_ref;
   logic                busy;
   logic                done;
   logic [OUT_W-1:0]    signature;
   logic                mismatch;
   logic [2*IN_W-1:0]   fail_vec;
   logic [2*IN_W:0]     fail_cnt;
   modport master (
      output start, y_in, y_ref,
      input  a_out, b_out, busy, done, signature, mismatch, fail_vec, fail_cnt
   );
   modport slave (
      input  start, y_in, y_ref,
      output a_out, b_out, busy, done, signature, mismatch, fail_vec, fail_cnt
   );
endinterface

// File: rtl/eco_pattern_checker.sv
// eco_pattern_checker: sweeps every {b,a} pattern, compares DUT vs golden outputs and compacts them into a MISR
module eco_pattern_checker #(
   parameter int              IN_W      = 4,
   parameter int              OUT_W     = 4,
   parameter logic [OUT_W-1:0] SEED      = 4'b0001,
   parameter logic [OUT_W-1:0] MISR_POLY = 4'b0011,
   parameter int              SETTLE    = 1
) (
   input logic clk,
   input logic rst,
   eco_pattern_checker_if.slave bus
);
   localparam int PW = 2 * IN_W;
   localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;
   state_t state, nxt;
   logic [PW:0]   cnt;
   logic [SW-1:0] wait_cnt;
   logic          last;
   assign last = cnt == {1'b0, {PW{1'b1}}};
   // state register
   always_ff @(posedge clk)
      if (rst) state <= S_IDLE;
      else state <= nxt;
   // next-state: one apply/settle/sample round per pattern, then a single done cycle
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   nxt = bus.start ? S_APPLY : S_IDLE;
         S_APPLY:  nxt = SETTLE == 0 ? S_SAMPLE : S_SETTLE;
         S_SETTLE: nxt = wait_cnt == SW'(SETTLE - 1) ? S_SAMPLE : S_SETTLE;
         S_SAMPLE: nxt = last ? S_DONE : S_APPLY;
         S_DONE:   nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end
   // datapath: stimulus, settle timer, signature compaction and failure bookkeeping
   always_ff @(posedge clk)
      if (rst) begin
         bus.a_out     <= '0;
         bus.b_out     <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.mismatch  <= 1'b0;
         bus.fail_vec  <= '0;
         bus.fail_cnt  <= '0;
         bus.signature <= SEED;
         cnt           <= '0;
         wait_cnt      <= '0;
      end else begin
         bus.done <= state == S_DONE;
         case (state)
            S_IDLE:
               if (bus.start) begin
                  cnt           <= '0;
                  bus.mismatch  <= 1'b0;
                  bus.fail_vec  <= '0;
                  bus.fail_cnt  <= '0;
                  bus.signature <= SEED;
                  bus.busy      <= 1'b1;
               end
            S_APPLY: begin
               {bus.b_out, bus.a_out} <= cnt[PW-1:0];
               wait_cnt               <= '0;
            end
            S_SETTLE: wait_cnt <= wait_cnt + 1'b1;
            S_SAMPLE: begin
               bus.signature <= {bus.signature[OUT_W-2:0], 1'b0}
                              ^ (bus.signature[OUT_W-1] ? MISR_POLY : '0) ^ bus.y_in;
               cnt <= cnt + 1'b1;
               if (bus.y_in != bus.y_ref) begin
                  bus.mismatch <= 1'b1;
                  bus.fail_cnt <= bus.fail_cnt + 1'b1;
                  if (!bus.mismatch) bus.fail_vec <= {bus.b_out, bus.a_out};
               end
            end
            S_DONE: bus.busy <= 1'b0;
            default: ;
         endcase
      end
endmodule
